// File: rtl/inference_pkg.sv
// Shared state encoding and default sizing for the MNIST run controller.
package inference_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    STREAM   = 3'd2,
    WAIT_RES = 3'd3,
    DONE     = 3'd4
  } seq_state_t;

  localparam int N_PIXELS_DEFAULT   = 784;
  localparam int CNT_W_DEFAULT      = 10;
  localparam int CLASS_W_DEFAULT    = 4;
  localparam int TMO_W_DEFAULT      = 24;
  localparam int TMO_CYCLES_DEFAULT = 1000000;

  function automatic logic is_active(seq_state_t s);
    return s inside {ARM, STREAM, WAIT_RES};
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Loadable down-counter; expire fires on the enabled cycle that finds it at zero.
module seq_watchdog #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = en & ~clr & (count == '0);

endmodule

// File: rtl/inference_sequencer.sv
// Run controller: arms the image loader, counts pixel beats, latches the class.
module inference_sequencer
  import inference_pkg::*;
#(
  parameter int N_PIXELS   = N_PIXELS_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int CLASS_W    = CLASS_W_DEFAULT,
  parameter int TMO_W      = TMO_W_DEFAULT,
  parameter int TMO_CYCLES = TMO_CYCLES_DEFAULT
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_areset,
  input  logic               go,
  input  logic               abort,
  output logic               img_start,
  input  logic               img_tvalid,
  input  logic               img_tready,
  input  logic [CLASS_W-1:0] res_tdata,
  input  logic               res_tvalid,
  output logic               res_tready,
  output logic               busy,
  output logic [CLASS_W-1:0] result,
  output logic               result_valid,
  output logic               done_irq,
  output logic               timeout_err,
  output logic               aborted,
  output logic [CNT_W-1:0]   pix_count,
  output logic [31:0]        cycle_count,
  output logic [15:0]        run_count
);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(N_PIXELS - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYCLES - 1);

  seq_state_t state, nxt;
  logic beat, accept, expire, wd_en, wd_clr;
  logic do_clear, do_abort, do_tmo, do_accept;

  assign beat   = img_tvalid & img_tready;
  assign accept = (state == WAIT_RES) & res_tvalid & res_tready;
  assign wd_en  = is_active(state);
  // Idle keeps the counter preloaded, so every run starts with a full window.
  assign wd_clr = (state == IDLE) | beat;

  seq_watchdog #(.W(TMO_W)) u_wd (
    .clk      (s_axi_aclk),
    .rst      (s_axi_areset),
    .clr      (wd_clr),
    .en       (wd_en),
    .load_val (TMO_LOAD),
    .expire   (expire)
  );

  always_comb begin
    nxt       = state;
    do_clear  = 1'b0;
    do_abort  = 1'b0;
    do_tmo    = 1'b0;
    do_accept = 1'b0;
    if (state != IDLE && abort) begin
      nxt      = IDLE;
      do_abort = 1'b1;
    end else begin
      unique case (state)
        IDLE: if (go) begin
          nxt      = ARM;
          do_clear = 1'b1;
        end
        ARM: if (beat) begin
          nxt = STREAM;
        end else if (expire) begin
          nxt    = IDLE;
          do_tmo = 1'b1;
        end
        STREAM: if (beat && pix_count == LAST) begin
          nxt = WAIT_RES;
        end else if (expire) begin
          nxt    = IDLE;
          do_tmo = 1'b1;
        end
        WAIT_RES: if (accept) begin
          nxt       = DONE;
          do_accept = 1'b1;
        end else if (expire) begin
          nxt    = IDLE;
          do_tmo = 1'b1;
        end
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state        <= IDLE;
      img_start    <= 1'b0;
      res_tready   <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      done_irq     <= 1'b0;
      timeout_err  <= 1'b0;
      aborted      <= 1'b0;
      pix_count    <= '0;
      cycle_count  <= '0;
      run_count    <= '0;
    end else begin
      state      <= nxt;
      img_start  <= (nxt == ARM);
      res_tready <= (nxt == WAIT_RES);
      busy       <= (nxt != IDLE);
      done_irq   <= do_abort | do_tmo | do_accept;
      if (do_clear) begin
        result_valid <= 1'b0;
        timeout_err  <= 1'b0;
        aborted      <= 1'b0;
        pix_count    <= '0;
        cycle_count  <= '0;
      end
      if (do_abort) aborted <= 1'b1;
      if (do_tmo) timeout_err <= 1'b1;
      if (do_accept) begin
        result       <= res_tdata;
        result_valid <= 1'b1;
        run_count    <= run_count + 1'b1;
      end
      // Beats after the last pixel land in WAIT_RES and are not counted.
      if (beat && !do_abort && (state == ARM || state == STREAM))
        pix_count <= pix_count + 1'b1;
      if (wd_en && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule
